// File: rtl/line_clear_engine.sv
// Locked-playfield owner: merges a locked 4x4 piece into the board, then collapses full rows bottom-up.
// active_piece_grid = {x[4:0], y[4:0], piece[15:0]} with piece bit dx*4+dy; base_state bit col*20+row.
module line_clear_engine (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         lock_req,
    input  logic [25:0]  active_piece_grid,
    input  logic         clear_board,
    output logic [199:0] base_state,
    output logic         busy,
    output logic         done,
    output logic [2:0]   lines_cleared,
    output logic         top_out
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MERGE = 2'd1;
    localparam logic [1:0] S_SCAN  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [9:0][19:0] screen_q, screen_d;
    logic [25:0]      piece_q, piece_d;
    logic [4:0]       row_q, row_d;
    logic [2:0]       lines_q, lines_d;
    logic             top_q, top_d;
    logic             row_full;

    // Board coordinates are signed ints so cells left of / above the board never wrap in.
    function automatic logic [9:0][19:0] merge_cells(input logic [9:0][19:0] scr,
                                                     input logic [25:0]      grid);
        logic [9:0][19:0] res;
        int bx, by;
        res = scr;
        for (int dx = 0; dx < 4; dx++) begin
            for (int dy = 0; dy < 4; dy++) begin
                if (grid[dx*4+dy]) begin
                    bx = int'(grid[25:21]) + dx - 4;
                    by = int'(grid[20:16]) + dy - 4;
                    if (bx >= 0 && bx < 10 && by >= 0 && by < 20)
                        res[4'(bx)][5'(by)] = 1'b1;
                end
            end
        end
        return res;
    endfunction

    function automatic logic merge_tops_out(input logic [25:0] grid);
        logic hit;
        int bx, by;
        hit = 1'b0;
        for (int dx = 0; dx < 4; dx++) begin
            for (int dy = 0; dy < 4; dy++) begin
                if (grid[dx*4+dy]) begin
                    bx = int'(grid[25:21]) + dx - 4;
                    by = int'(grid[20:16]) + dy - 4;
                    if (bx >= 0 && bx < 10 && by < 0)
                        hit = 1'b1;
                end
            end
        end
        return hit;
    endfunction

    // Rows 0..r each take the row above them; row 0 refills empty.
    function automatic logic [9:0][19:0] collapse_row(input logic [9:0][19:0] scr,
                                                      input logic [4:0]       r);
        logic [9:0][19:0] res;
        res = scr;
        for (int c = 0; c < 10; c++) begin
            for (int j = 0; j < 20; j++) begin
                if (j == 0)
                    res[c][j] = 1'b0;
                else if (j <= int'(r))
                    res[c][j] = scr[c][j-1];
            end
        end
        return res;
    endfunction

    always_comb begin
        row_full = 1'b1;
        for (int c = 0; c < 10; c++)
            row_full = row_full & screen_q[c][row_q];
    end

    always_comb begin
        state_d  = state_q;
        screen_d = screen_q;
        piece_d  = piece_q;
        row_d    = row_q;
        lines_d  = lines_q;
        top_d    = top_q;
        case (state_q)
            S_IDLE: begin
                if (lock_req) begin
                    piece_d = active_piece_grid;
                    lines_d = 3'd0;
                    state_d = S_MERGE;
                end else if (clear_board) begin
                    screen_d = '0;
                    top_d    = 1'b0;
                end
            end
            S_MERGE: begin
                screen_d = merge_cells(screen_q, piece_q);
                if (merge_tops_out(piece_q))
                    top_d = 1'b1;
                row_d   = 5'd19;
                state_d = S_SCAN;
            end
            S_SCAN: begin
                // A collapsed row is rescanned at the same pointer, since new content dropped into it.
                if (row_full) begin
                    screen_d = collapse_row(screen_q, row_q);
                    if (lines_q != 3'd7)
                        lines_d = lines_q + 3'd1;
                end else if (row_q != 5'd0) begin
                    row_d = row_q - 5'd1;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            screen_q <= '0;
            piece_q  <= '0;
            row_q    <= '0;
            lines_q  <= '0;
            top_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            screen_q <= screen_d;
            piece_q  <= piece_d;
            row_q    <= row_d;
            lines_q  <= lines_d;
            top_q    <= top_d;
        end
    end

    assign base_state    = screen_q;
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);
    assign lines_cleared = lines_q;
    assign top_out       = top_q;

endmodule

// File: tb/tb_line_clear_engine.sv
// Bench for line_clear_engine: lock table driven through a scoreboard backed by a compaction board model.
module tb_line_clear_engine;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         lock_req;
    logic [25:0]  grid;
    logic         clear_board;
    logic [199:0] base_state;
    logic         busy;
    logic         done;
    logic [2:0]   lines_cleared;
    logic         top_out;

    line_clear_engine dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .lock_req         (lock_req),
        .active_piece_grid(grid),
        .clear_board      (clear_board),
        .base_state       (base_state),
        .busy             (busy),
        .done             (done),
        .lines_cleared    (lines_cleared),
        .top_out          (top_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [199:0] board;
        logic [2:0]   lines;
        logic         top;
        int           off;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic        clr;
        logic [15:0] piece;
        logic [4:0]  x;
        logic [4:0]  y;
        logic [2:0]  lines;
        int          spot_col;
        logic [19:0] spot_val;
    } vec_t;
    vec_t vecs[17];

    bit mb [10][20];
    bit mtop;

    task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < 10; c++)
            for (int r = 0; r < 20; r++)
                mb[c][r] = 1'b0;
        mtop = 1'b0;
    endtask

    // Merge, then compact surviving rows toward the bottom.
    task automatic model_lock(input logic [15:0] pc, input logic [4:0] x, input logic [4:0] y);
        bit tmp [10][20];
        int bx, by, w;
        bit full;
        for (int dx = 0; dx < 4; dx++)
            for (int dy = 0; dy < 4; dy++)
                if (pc[dx*4+dy]) begin
                    bx = int'(x) + dx - 4;
                    by = int'(y) + dy - 4;
                    if (bx >= 0 && bx < 10) begin
                        if (by >= 0 && by < 20) mb[bx][by] = 1'b1;
                        else if (by < 0) mtop = 1'b1;
                    end
                end
        for (int c = 0; c < 10; c++)
            for (int r = 0; r < 20; r++)
                tmp[c][r] = 1'b0;
        w = 19;
        for (int r = 19; r >= 0; r--) begin
            full = 1'b1;
            for (int c = 0; c < 10; c++) full = full & mb[c][r];
            if (!full) begin
                for (int c = 0; c < 10; c++) tmp[c][w] = mb[c][r];
                w--;
            end
        end
        for (int c = 0; c < 10; c++)
            for (int r = 0; r < 20; r++)
                mb[c][r] = tmp[c][r];
    endtask

    function automatic logic [199:0] flat();
        logic [199:0] f;
        f = '0;
        for (int c = 0; c < 10; c++)
            for (int r = 0; r < 20; r++)
                f[8'(c*20 + r)] = mb[c][r];
        return f;
    endfunction

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done) check("spurious_done", 200'(done), 200'(0));
        end
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear_board = 1'b1;
        @(negedge clk);
        clear_board = 1'b0;
        model_clear();
        check("clear_board_screen", base_state, 200'(0));
        check("clear_board_top", 200'(top_out), 200'(0));
    endtask

    // Optional inject drives a lock plus clear while the engine is busy; both must be ignored.
    task automatic do_lock(input logic [15:0] pc, input logic [4:0] x, input logic [4:0] y,
                           input logic clr_too, input logic [2:0] exp_lines, input logic inject);
        exp_t e;
        int   acc;
        bit   seen;
        @(negedge clk);
        grid        = {x, y, pc};
        lock_req    = 1'b1;
        clear_board = clr_too;
        @(posedge clk);
        #1;
        acc         = cyc;
        lock_req    = 1'b0;
        clear_board = 1'b0;
        model_lock(pc, x, y);
        e.board = flat();
        e.lines = exp_lines;
        e.top   = mtop;
        e.off   = 22 + int'(exp_lines);
        sb.push_back(e);
        seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            @(negedge clk);
            if (i == 0) check("busy_after_accept", 200'(busy), 200'(1));
            if (inject && i == 5) begin
                grid        = {5'd13, 5'd23, 16'hFFFF};
                lock_req    = 1'b1;
                clear_board = 1'b1;
            end
            if (inject && i == 7) begin
                lock_req    = 1'b0;
                clear_board = 1'b0;
            end
            if (done) seen = 1'b1;
        end
        e = sb.pop_front();
        check("done_seen", 200'(seen), 200'(1));
        if (seen) begin
            // Offset counts the accept edge as cycle t, so done's cycle is t + edges elapsed + 1.
            check("done_cycle", 200'(cyc - acc + 1), 200'(e.off));
            check("lines_cleared", 200'(lines_cleared), 200'(e.lines));
            check("board", base_state, e.board);
            check("top_out", 200'(top_out), 200'(e.top));
        end
        @(negedge clk);
        check("done_one_cycle", 200'(done), 200'(0));
        check("idle_after_done", 200'(busy), 200'(0));
    endtask

    initial begin
        rst_n       = 1'b0;
        lock_req    = 1'b0;
        clear_board = 1'b0;
        grid        = '0;
        model_clear();

        vecs[0]  = '{1'b1, 16'h0660, 5'd4,  5'd21, 3'd0, 1,  20'hC0000};
        vecs[1]  = '{1'b1, 16'h1111, 5'd4,  5'd23, 3'd0, -1, 20'h0};
        vecs[2]  = '{1'b0, 16'h1111, 5'd8,  5'd23, 3'd0, -1, 20'h0};
        vecs[3]  = '{1'b0, 16'h0001, 5'd12, 5'd23, 3'd0, 8,  20'h80000};
        vecs[4]  = '{1'b0, 16'h000F, 5'd13, 5'd20, 3'd1, 9,  20'hE0000};
        for (int i = 0; i < 9; i++)
            vecs[5+i] = '{(i == 0), 16'h000F, 5'(5 + i), 5'd20, 3'd0, -1, 20'h0};
        vecs[14] = '{1'b0, 16'h000F, 5'd4,  5'd20, 3'd4, 0,  20'h0};
        vecs[15] = '{1'b1, 16'h000F, 5'd4,  5'd3,  3'd0, 0,  20'h00007};
        vecs[16] = '{1'b0, 16'h000F, 5'd0,  5'd20, 3'd0, 0,  20'h00007};

        repeat (3) @(negedge clk);
        check("reset_busy", 200'(busy), 200'(0));
        check("reset_done", 200'(done), 200'(0));
        check("reset_lines", 200'(lines_cleared), 200'(0));
        check("reset_top", 200'(top_out), 200'(0));
        check("reset_screen", base_state, 200'(0));
        rst_n = 1'b1;
        idle_cycles(2);

        for (int v = 0; v < 17; v++) begin
            if (vecs[v].clr) do_clear();
            do_lock(vecs[v].piece, vecs[v].x, vecs[v].y, 1'b0, vecs[v].lines, 1'b0);
            if (vecs[v].spot_col >= 0)
                check("spot_column", 200'(base_state[8'(vecs[v].spot_col*20) +: 20]),
                      200'(vecs[v].spot_val));
        end

        check("top_sticky", 200'(top_out), 200'(1));
        do_clear();

        do_lock(16'h0660, 5'd4, 5'd21, 1'b0, 3'd0, 1'b1);
        idle_cycles(30);
        check("ignored_lock_board", base_state, flat());
        check("ignored_lock_lines", 200'(lines_cleared), 200'(0));

        do_lock(16'h0660, 5'd8, 5'd21, 1'b1, 3'd0, 1'b0);
        check("lock_beats_clear", 200'(base_state[8'(20) +: 20]), 200'(20'hC0000));

        @(negedge clk);
        grid     = {5'd4, 5'd3, 16'h000F};
        lock_req = 1'b1;
        @(posedge clk);
        #1;
        lock_req = 1'b0;
        repeat (10) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_busy", 200'(busy), 200'(0));
        check("async_reset_done", 200'(done), 200'(0));
        check("async_reset_lines", 200'(lines_cleared), 200'(0));
        check("async_reset_top", 200'(top_out), 200'(0));
        check("async_reset_screen", base_state, 200'(0));
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        idle_cycles(30);
        check("post_reset_screen", base_state, 200'(0));
        check("post_reset_busy", 200'(busy), 200'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
